// File: rtl/ita_requant_pipe.sv
// ita_requant_pipe: two-stage, multi-lane requantizer (multiply, shift, offset, saturate, ReLU)
// with valid/ready back-pressure and a sticky saturation counter.
// Optional build macro: ITA_REQUANT_ROUND_EN selects round-half-up instead of floor on the shift.

// Per-lane datapath: S1 product register, S2 shift/offset/saturate/ReLU and output register.
module ita_requant_lane #(
  parameter int InWidth    = 26,
  parameter int OutWidth   = 8,
  parameter int ConstWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ld1_i,
  input  logic                  ld2_i,
  input  logic [InWidth-1:0]    data_i,
  input  logic [ConstWidth-1:0] mult_i,
  input  logic [ConstWidth-1:0] shift_i,
  input  logic [OutWidth-1:0]   add_i,
  input  logic                  relu_i,
  output logic                  sat_o,
  output logic [OutWidth-1:0]   data_o
);
  localparam int PW = InWidth + ConstWidth + 1;
  localparam int RW = PW + 2;
  localparam logic signed [RW-1:0] MaxV = {{(RW-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
  localparam logic signed [RW-1:0] MinV = ~MaxV;

  logic signed [PW-1:0] prod_d, prod_q;
  logic signed [PW:0]   p_g, s;
  logic signed [RW-1:0] r;
  logic [OutWidth-1:0]  y;

  // signed data times zero-extended multiplier; PW bits always hold the exact product
  assign prod_d = $signed({{(PW-InWidth){data_i[InWidth-1]}}, data_i})
                * $signed({{(PW-ConstWidth){1'b0}}, mult_i});
  assign p_g    = $signed({prod_q[PW-1], prod_q});

  // S1 product register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    prod_q <= '0;
    else if (ld1_i) prod_q <= prod_d;
  end

`ifdef ITA_REQUANT_ROUND_EN
  logic signed [PW:0] rnd;
  // round-half-up: add half an LSB of the result in the guard-bit-extended product, then floor
  always_comb begin
    rnd = '0;
    s   = p_g;
    if (32'(shift_i) > 32'(PW)) begin
      s = '0;  // |prod| < 2^(shift-1): rounds to zero for either sign
    end else if (shift_i != '0) begin
      rnd = (PW+1)'(1) << (shift_i - ConstWidth'(1));
      s   = (p_g + rnd) >>> shift_i;
    end
  end
`else
  // floor shift; oversized shifts fill with the sign, giving 0 or -1
  assign s = p_g >>> shift_i;
`endif

  assign r     = $signed({s[PW], s}) + $signed({{(RW-OutWidth){add_i[OutWidth-1]}}, add_i});
  assign sat_o = (r > MaxV) || (r < MinV);

  // clamp to the output range, then optional ReLU (saturation flag is taken before ReLU)
  always_comb begin
    if (r > MaxV)      y = MaxV[OutWidth-1:0];
    else if (r < MinV) y = MinV[OutWidth-1:0];
    else               y = r[OutWidth-1:0];
    if (relu_i && y[OutWidth-1]) y = '0;
  end

  // S2 output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    data_o <= '0;
    else if (ld2_i) data_o <= y;
  end
endmodule

module ita_requant_pipe #(
  parameter int NLanes     = 16,
  parameter int InWidth    = 26,
  parameter int OutWidth   = 8,
  parameter int ConstWidth = 8,
  parameter int NConsts    = 6,
  parameter int CntWidth   = 32,
  localparam int SelWidth  = (NConsts > 1) ? $clog2(NConsts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NLanes*InWidth-1:0]      data_i,
  input  logic [SelWidth-1:0]            sel_i,
  input  logic [NConsts*ConstWidth-1:0]  mult_i,
  input  logic [NConsts*ConstWidth-1:0]  shift_i,
  input  logic [NConsts*OutWidth-1:0]    add_i,
  input  logic [NConsts-1:0]             relu_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NLanes*OutWidth-1:0]     data_o,
  input  logic                           clear_i,
  output logic [CntWidth-1:0]            sat_cnt_o
);
  localparam int PopWidth = $clog2(NLanes + 1);

  logic [2:1]            vld_pipe;
  logic                  adv1, adv2, ld1, ld2;
  logic [SelWidth-1:0]   sel_c;
  logic [ConstWidth-1:0] mult_sel, shift_q;
  logic [OutWidth-1:0]   add_q;
  logic                  relu_q;
  logic [NLanes-1:0]     sat;
  logic [PopWidth-1:0]   pop;
  logic [CntWidth:0]     cnt_sum;

  assign valid_o = vld_pipe[2];
  assign adv2    = !vld_pipe[2] || ready_i;
  assign adv1    = !vld_pipe[1] || adv2;
  assign ready_o = adv1;
  assign ld1     = valid_i && adv1;
  assign ld2     = vld_pipe[1] && adv2;

  // out-of-range selects fall back to set 0 rather than reading past the constant arrays
  assign sel_c    = (32'(sel_i) < 32'(NConsts)) ? sel_i : '0;
  assign mult_sel = mult_i[sel_c*ConstWidth +: ConstWidth];

  // stage valids advance independently so S2 can drain while S1 fills
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe <= '0;
    else begin
      if (adv1) vld_pipe[1] <= valid_i;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 captures the beat's shift/offset/ReLU so later constant changes don't touch it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      add_q   <= '0;
      relu_q  <= 1'b0;
    end else if (ld1) begin
      shift_q <= shift_i[sel_c*ConstWidth +: ConstWidth];
      add_q   <= add_i[sel_c*OutWidth +: OutWidth];
      relu_q  <= relu_i[sel_c];
    end
  end

  for (genvar g = 0; g < NLanes; g++) begin : g_lane
    ita_requant_lane #(
      .InWidth(InWidth), .OutWidth(OutWidth), .ConstWidth(ConstWidth)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ld1_i  (ld1),
      .ld2_i  (ld2),
      .data_i (data_i[g*InWidth +: InWidth]),
      .mult_i (mult_sel),
      .shift_i(shift_q),
      .add_i  (add_q),
      .relu_i (relu_q),
      .sat_o  (sat[g]),
      .data_o (data_o[g*OutWidth +: OutWidth])
    );
  end

  // popcount of saturated lanes in the beat sitting in S1
  always_comb begin
    pop = '0;
    for (int i = 0; i < NLanes; i++) pop = pop + PopWidth'(sat[i]);
  end

  assign cnt_sum = {1'b0, sat_cnt_o} + (CntWidth+1)'(pop);

  // sticky saturation counter; clear wins over the same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      sat_cnt_o <= '0;
    else if (clear_i) sat_cnt_o <= '0;
    else if (ld2)     sat_cnt_o <= cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
  end
endmodule

// File: tb/tb_ita_requant_pipe.sv
// Bench for ita_requant_pipe: directed steps plus random traffic scored against
// an arithmetic reference model (floor / round-half-up division, clamp, ReLU).
module tb_ita_requant_pipe;
  localparam int NL = 16, IW = 26, OW = 8, CW = 8, NC = 6, SW = 3;

  logic                 clk_i = 0, rst_ni = 0;
  logic                 valid_i = 0, ready_i = 1, clear_i = 0;
  logic                 ready_o, valid_o;
  logic [NL*IW-1:0]     data_i = '0;
  logic [SW-1:0]        sel_i = '0;
  logic [NC*CW-1:0]     mult_i = '0, shift_i = '0;
  logic [NC*OW-1:0]     add_i = '0;
  logic [NC-1:0]        relu_i = '0;
  logic [NL*OW-1:0]     data_o;
  logic [31:0]          sat_cnt_o;

  ita_requant_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .sel_i(sel_i), .mult_i(mult_i), .shift_i(shift_i),
    .add_i(add_i), .relu_i(relu_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .clear_i(clear_i), .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int cm[NC], cs[NC], ca[NC];
  bit cr[NC];
  logic [NL*OW-1:0] q[$];
  longint exp_cnt = 0;
  bit acc_flag = 0, prev_stall = 0;
  logic [NL*OW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint sh);
    longint d = longint'(1) << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic void ref_lane(input longint d, m, sh, a, input bit relu,
                                   output longint y, output bit sat);
    longint p, s, r, lim;
    p = d * m;
`ifdef ITA_REQUANT_ROUND_EN
    if (sh == 0)       s = p;
    else if (sh >= 60) s = 0;
    else               s = fdiv(p + (longint'(1) << (sh - 1)), sh);
`else
    if (sh >= 60) s = (p < 0) ? -1 : 0;
    else          s = fdiv(p, sh);
`endif
    lim = longint'(1) << (OW - 1);
    r   = s + a;
    sat = (r >= lim) || (r < -lim);
    y   = (r >= lim) ? lim - 1 : (r < -lim) ? -lim : r;
    if (relu && y < 0) y = 0;
  endfunction

  task automatic apply_consts();
    for (int k = 0; k < NC; k++) begin
      mult_i[k*CW +: CW]  = CW'(cm[k]);
      shift_i[k*CW +: CW] = CW'(cs[k]);
      add_i[k*OW +: OW]   = OW'(ca[k]);
      relu_i[k]           = cr[k];
    end
  endtask

  // per-cycle observation at the negedge: ready rule, stall hold, scoreboard, counter model
  task automatic monitor();
    logic [NL*OW-1:0] e;
    longint y;
    bit st;
    int sel, ns;
    acc_flag = 0;
    chk("ready_o", ready_o, !(q.size() == 2 && !ready_i));
    if (prev_stall) chk("stall_hold", {valid_o, data_o}, {1'b1, prev_data});
    if (clear_i) exp_cnt = 0;
    if (valid_o && ready_i) begin
      if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else chk("beat", data_o, q.pop_front());
    end
    if (valid_i && ready_o) begin
      sel = int'(sel_i);
      ns  = 0;
      e   = '0;
      for (int i = 0; i < NL; i++) begin
        ref_lane(longint'($signed(data_i[i*IW +: IW])), cm[sel], cs[sel], ca[sel], cr[sel], y, st);
        e[i*OW +: OW] = OW'(y);
        ns += int'(st);
      end
      q.push_back(e);
      exp_cnt += ns;
      acc_flag = 1;
    end
    prev_stall = valid_o && !ready_i;
    prev_data  = data_o;
  endtask

  task automatic cyc();
    apply_consts();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < NL; i++) data_i[i*IW +: IW] = IW'(v);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NL; i++)
      if ($urandom_range(0, 1) == 1) data_i[i*IW +: IW] = IW'($urandom);
      else data_i[i*IW +: IW] = IW'(longint'($urandom_range(0, 4000)) - 2000);
  endtask

  task automatic rand_consts();
    for (int k = 0; k < NC; k++) begin
      cm[k] = int'($urandom_range(0, 255));
      cs[k] = int'($urandom_range(0, 45));
      ca[k] = int'($urandom_range(0, 255)) - 128;
      cr[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_c(input int k, m, s, a, input bit r);
    cm[k] = m; cs[k] = s; ca[k] = a; cr[k] = r;
  endtask

  task automatic send(input int sel);
    sel_i = SW'(sel);
    valid_i = 1;
    for (int n = 0; n <= 50; n++) begin
      cyc();
      if (acc_flag) break;
    end
    if (!acc_flag) chk("send_timeout", 0, 1);
    valid_i = 0;
  endtask

  task automatic drain();
    ready_i = 1;
    valid_i = 0;
    for (int n = 0; n < 20; n++) begin
      if (q.size() == 0) break;
      cyc();
    end
    chk("drain_empty", 128'(q.size()), 0);
  endtask

  task automatic wait_out();
    for (int n = 0; n < 10; n++) begin
      if (valid_o) break;
      cyc();
    end
    if (!valid_o) chk("out_timeout", 0, 1);
  endtask

  initial begin
    int b;
    for (int k = 0; k < NC; k++) set_c(k, 0, 0, 0, 0);
    apply_consts();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_sat_cnt", sat_cnt_o, 0);
    rst_ni = 1;

    // basic value and two-cycle latency
    set_c(0, 3, 4, -2, 0);
    fill(100);
    send(0);
    chk("lat_t1_valid", valid_o, 0);
    cyc();
    chk("lat_t2_valid", valid_o, 1);
`ifdef ITA_REQUANT_ROUND_EN
    chk("basic", data_o[7:0], 8'd17);
`else
    chk("basic", data_o[7:0], 8'd16);
`endif
    drain();

    // negative and ReLU
    set_c(1, 3, 4, 0, 0);
    set_c(2, 3, 4, 0, 1);
    fill(-100);
    send(1);
    wait_out();
    chk("neg", data_o[7:0], 8'hED);
    drain();
    send(2);
    wait_out();
    chk("relu", data_o[7:0], 8'h00);
    drain();
    chk("relu_sat_cnt", sat_cnt_o, 0);

    // saturation both ways
    set_c(3, 3, 4, 5, 0);
    set_c(4, 1, 0, 0, 0);
    fill(1000);
    send(3);
    wait_out();
    chk("sat_pos", data_o, {NL{8'h7f}});
    drain();
    chk("sat_cnt_16", sat_cnt_o, 16);
    fill(-100000);
    send(4);
    wait_out();
    chk("sat_neg", data_o, {NL{8'h80}});
    drain();
    chk("sat_cnt_32", sat_cnt_o, 32);

    // back-pressure: 10 beats, ready_i low for cycles 3..7
    rand_consts();
    b = 0;
    rand_data();
    for (int c = 0; c < 40; c++) begin
      ready_i = !(c >= 3 && c <= 7);
      valid_i = (b < 10);
      sel_i = SW'(b % NC);
      cyc();
      if (acc_flag) begin
        b++;
        rand_data();
      end
    end
    valid_i = 0;
    chk("bp_beats_sent", b, 10);
    drain();

    // alternating constant sets on back-to-back beats
    set_c(0, 7, 2, -3, 0);
    set_c(5, 200, 10, 20, 1);
    for (int n = 0; n < 8; n++) begin
      rand_data();
      send((n % 2 == 1) ? 5 : 0);
    end
    drain();

    // oversized shift on a negative product
    set_c(4, 5, 40, 10, 0);
    fill(-7);
    send(4);
    wait_out();
`ifdef ITA_REQUANT_ROUND_EN
    chk("shift40", data_o[7:0], 8'h0A);
`else
    chk("shift40", data_o[7:0], 8'h09);
`endif
    drain();
    chk("sat_cnt_dir", sat_cnt_o, 32'(exp_cnt));

    // random traffic with constants changing under in-flight beats
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 7) == 0) rand_consts();
      ready_i = ($urandom_range(0, 3) != 0);
      valid_i = ($urandom_range(0, 3) != 0);
      sel_i   = SW'($urandom_range(0, NC - 1));
      rand_data();
      cyc();
    end
    valid_i = 0;
    drain();
    chk("sat_cnt_rand", sat_cnt_o, 32'(exp_cnt));

    // clear in the cycle a saturating beat loads S2
    set_c(3, 3, 4, 5, 0);
    fill(1000);
    send(3);
    clear_i = 1;
    cyc();
    clear_i = 0;
    chk("clear_cnt", sat_cnt_o, 0);
    drain();
    chk("clear_cnt_after", sat_cnt_o, 0);

    // reset with both stages full
    ready_i = 0;
    rand_data();
    send(3);
    rand_data();
    send(3);
    chk("full_ready_o", ready_o, 0);
    rst_ni = 0;
    #1;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_data_o", data_o, 0);
    chk("midrst_sat_cnt", sat_cnt_o, 0);
    q.delete();
    exp_cnt = 0;
    prev_stall = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1;
    ready_i = 1;
    repeat (5) cyc();
    chk("post_rst_valid_o", valid_o, 0);
    set_c(0, 3, 4, -2, 0);
    fill(100);
    send(0);
    drain();
    chk("post_rst_sat_cnt", sat_cnt_o, 32'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ita_requant_pipe.md
# ita_requant_pipe

Parametrised, multi-lane requantization pipeline converting wide signed accumulator outputs to WI-bit activations. It sits between the PE output stage and the output FIFO. It replaces the single-step, fixed-width requantizer with:
- per-beat constant-set selection (one set per step);
- valid/ready back-pressure;
- optional ReLU;
- a running saturation counter for debug and calibration.

## Interface
Parameters:
- NLanes, 16: lanes processed per beat
- InWidth, 26: signed accumulator width (WO)
- OutWidth, 8: signed output width (WI)
- ConstWidth, 8: width of unsigned multiplier and of shift amount (EMS)
- NConsts, 6: number of constant sets, indexed by step (Q..OW)
- CntWidth, 32: saturation counter width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  pipeline can accept beat
- data_i  in  NLanes×InWidth  signed accumulators
- sel_i  in  idx_width(NConsts)  constant-set index, sampled with beat
- mult_i  in  NConsts×ConstWidth  unsigned multipliers (eps_mult)
- shift_i  in  NConsts×ConstWidth  right-shift amounts
- add_i  in  NConsts×OutWidth  signed offsets
- relu_i  in  NConsts×1  per-set ReLU enable
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts beat
- data_o  out  NLanes×OutWidth  requantized lanes
- clear_i  in  1  synchronous clear of saturation counter
- sat_cnt_o  out  CntWidth  saturated-lane count

## Operation
Stage 1 (S1), on accept:
- Registers the per-lane product: signed data × zero-extended mult[sel].
- Product width is InWidth+ConstWidth+1.
- Registers shift[sel], add[sel] and relu[sel] alongside the product.

Stage 2 (S2), per lane:
- Computes `s = prod >>> shift` (arithmetic shift, i.e. floor).
- If shift ≥ product width, s = 0 for non-negative products and −1 for negative products.
- Computes `r = s + sign-extended add`, held wide enough that it cannot overflow.
- Saturates r to [−2^(OutWidth−1), 2^(OutWidth−1)−1].
- If relu is set, then applies y = max(0, saturated r).
- Registers y into data_o.

Saturation flag:
- A lane counts as saturated when r lies outside the output range. This is evaluated before ReLU.
- On each S2 load, sat_cnt_o increases by the popcount of saturated lanes in the beat.
- sat_cnt_o sticks at all-ones; it does not wrap.
- clear_i takes priority: when clear_i is asserted, sat_cnt_o becomes 0 and that cycle's increment is discarded.

Sampling: constants are read combinationally at S1 load. Changing constants after acceptance does not affect beats already in flight.

## Timing
- Reset: valid_o=0, data_o=0, sat_cnt_o=0, all internal stage valids 0. No beat survives a reset, including one asserted mid-operation.
- Latency: a beat accepted in cycle t appears with valid_o=1 in cycle t+2, provided the pipeline is not stalled.
- Throughput: one beat per cycle.
- Handshake:
  - adv2 = !valid_o || ready_i
  - adv1 = !s1_valid || adv2
  - ready_o = adv1 (combinational from ready_i)
  - A beat transfers on valid&&ready on both sides.
- Stall: while valid_o && !ready_i, data_o and valid_o hold stable and S1 holds. ready_o drops only when both stages are full.
- Drain and fill in the same cycle: S2 takes S1's beat while S1 takes a new beat.
- Neither valid_i nor valid_o depends combinationally on the other handshake signal.

## Configuration
Macro: `ITA_REQUANT_ROUND_EN`.
- **Defined:** round-half-up before the shift. For shift>0, s = (prod + 2^(shift−1)) >>> shift, computed with one guard bit to avoid overflow. For shift=0, no rounding addend is applied.
- **Undefined:** truncating arithmetic shift (floor), bit-exact with the current golden model.

## Test plan
- **Basic:** data=100, mult=3, shift=4, add=−2, relu=0.
  - Without `ITA_REQUANT_ROUND_EN`: 16 (300>>>4 = 18, then 18−2).
  - With `ITA_REQUANT_ROUND_EN`: 17.
  - Output arrives 2 cycles after acceptance.
- **Negative and ReLU:** data=−100, mult=3, shift=4, add=0.
  - relu=0: output −19 in both configurations.
  - relu=1: output 0, and sat_cnt_o is unchanged.
- **Saturation:** all 16 lanes data=1000, mult=3, shift=4, add=5 → every lane 127 and sat_cnt_o += 16. Then data=−100000, mult=1, shift=0 → −128 and sat_cnt_o += 16 (total 32).
- **Back-pressure:** stream 10 beats with ready_i low for cycles 3–7.
  - No beat is lost or duplicated; order is preserved.
  - data_o is stable while stalled.
  - ready_o is low only while both stages are full.
- **Set select and edges:** alternate sel=0 and sel=5 with distinct constants on back-to-back beats → each beat uses its own set. Also check shift=40 on a negative product → s=−1, so output = add−1.
- **Clear and reset:** assert clear_i in a cycle where a saturating beat loads S2 → sat_cnt_o=0. Assert rst_ni low mid-stream with both stages full → valid_o=0 and data_o=0 immediately, and no stale beat after release.
